// File: rtl/seq_square_ctrl_if.sv
// Start/done handshake bundle between a requesting controller and the sequential squarer.
// The controller drives start/num; the squarer returns busy, done and the 2N-bit square.
interface seq_square_ctrl_if #(
   parameter int N = 4
);
   logic           start;
   logic [N-1:0]   num;
   logic           busy;
   logic           done;
   logic [2*N-1:0] result;

   modport master (
      output start,
      output num,
      input  busy,
      input  done,
      input  result
   );

   modport slave (
      input  start,
      input  num,
      output busy,
      output done,
      output result
   );
endinterface

// File: rtl/seq_square_ctrl.sv
// Sequential shift-add squarer: one partial product per cycle for N cycles, then a one-cycle done strobe.
// The square stays on result until the next operation completes.
module seq_square_ctrl #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   seq_square_ctrl_if.slave bus
);

   localparam int              CNT_W    = (N > 1) ? $clog2(N) : 1;
   localparam int              RES_W    = 2 * N;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [N-1:0]     r_a;
   logic [RES_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [RES_W-1:0] r_result;
   logic             r_busy;
   logic             r_done;

   logic [RES_W-1:0] w_pp;
   logic [RES_W-1:0] w_acc_nxt;

   // Operand zero-extended to the result width before shifting, gated by the selected bit.
   function automatic logic [RES_W-1:0] partial_product(
      input logic [N-1:0]     a,
      input logic [CNT_W-1:0] sh
   );
      logic [RES_W-1:0] ext;
      ext = {{N{1'b0}}, a};
      if (a[sh]) begin
         return ext << sh;
      end
      return '0;
   endfunction

   assign w_pp      = partial_product(r_a, r_cnt);
   assign w_acc_nxt = r_acc + w_pp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_a     <= bus.num;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
               // The last step publishes the sum including its own partial product.
               if (r_cnt == CNT_LAST) begin
                  r_result <= w_acc_nxt;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = r_busy;
   // Masking with rst keeps a strobe from showing during a reset cycle that lands on DONE.
   assign bus.done   = r_done & ~rst;
   assign bus.result = r_result;

   a_done_single: assert property (@(posedge clk) disable iff (rst) r_done |=> !r_done);
   a_cnt_range:   assert property (@(posedge clk) disable iff (rst)
                                   (r_state == S_CALC) |-> (r_cnt <= CNT_LAST));
   a_busy_state:  assert property (@(posedge clk) disable iff (rst)
                                   r_busy == (r_state != S_IDLE));

endmodule
